// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: EX-stage sequencer for the multi-cycle multiply/divide unit.
// Issues one start pulse per MULT/MULTU/DIV/DIVU, holds the pipeline until the
// unit finishes, commits {hi,lo}, and handles MTHI/MTLO, flush and a watchdog.
module mult_div_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                stall_all,
    input  logic                op_valid,
    input  logic [5:0]          op_funct,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    output logic                md_start,
    output logic [5:0]          md_funct,
    output logic [DATA_W-1:0]   md_a,
    output logic [DATA_W-1:0]   md_b,
    output logic                md_abort,
    input  logic                md_done,
    input  logic [2*DATA_W-1:0] md_result,
    output logic                stall_req,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic                busy,
    output logic                timeout_err
);

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;

    logic is_md_op;
    logic issue;
    logic move_ok;
    logic timed_out;

    // Decode the EX instruction and derive the handshake outputs from the current state.
    always_comb begin
        is_md_op  = (op_funct == F_MULT) || (op_funct == F_MULTU) ||
                    (op_funct == F_DIV)  || (op_funct == F_DIVU);
        issue     = op_valid && is_md_op && !stall_all && !flush;
        move_ok   = op_valid && !stall_all && !flush;
        timed_out = (state == BUSY) && !md_done && (counter == CNT_LAST);
        md_start  = (state == IDLE) && issue;
        stall_req = ((state == IDLE) && issue) || ((state == BUSY) && !md_done);
        md_abort  = (state == BUSY) && (flush || timed_out);
        busy      = (state == BUSY);
    end

    // Sequencer: latch the op on issue, wait for done, commit HI/LO; flush and watchdog return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            md_funct    <= '0;
            md_a        <= '0;
            md_b        <= '0;
            hi          <= '0;
            lo          <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        md_funct <= op_funct;
                        md_a     <= op_a;
                        md_b     <= op_b;
                        counter  <= '0;
                        state    <= BUSY;
                    end else if (move_ok) begin
                        if (op_funct == F_MTHI) begin
                            hi <= op_a;
                        end else if (op_funct == F_MTLO) begin
                            lo <= op_a;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (md_done) begin
                        hi    <= md_result[2*DATA_W-1:DATA_W];
                        lo    <= md_result[DATA_W-1:0];
                        state <= stall_all ? HOLD : IDLE;
                    end else if (counter == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                HOLD: begin
                    if (flush || !stall_all) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: directed self-checking bench for mult_div_ctrl.
// The bench plays the role of the mult/div unit, asserting md_done on chosen cycles.
module tb_mult_div_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall_all;
    logic        op_valid;
    logic [5:0]  op_funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        md_start;
    logic [5:0]  md_funct;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_abort;
    logic        md_done;
    logic [63:0] md_result;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    mult_div_ctrl #(.DATA_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_all(stall_all),
        .op_valid(op_valid), .op_funct(op_funct), .op_a(op_a), .op_b(op_b),
        .md_start(md_start), .md_funct(md_funct), .md_a(md_a), .md_b(md_b),
        .md_abort(md_abort), .md_done(md_done), .md_result(md_result),
        .stall_req(stall_req), .hi(hi), .lo(lo), .busy(busy),
        .timeout_err(timeout_err)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op in EX, answer with md_done on cycle done_at after the issue cycle.
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input int done_at, input logic [63:0] res, input bit stall_at_done,
                                 output int stalls, output int starts);
        op_valid  = 1'b1;
        op_funct  = f;
        op_a      = a;
        op_b      = b;
        md_result = res;
        stalls    = 0;
        starts    = 0;
        for (int c = 0; c <= done_at; c++) begin
            md_done = (c == done_at);
            if (c == done_at) stall_all = stall_at_done;
            #1;
            if (stall_req) stalls++;
            if (md_start) starts++;
            if (c == 1) begin
                checkOutput("md_a_latched", 64'(md_a), 64'(a));
                checkOutput("md_b_latched", 64'(md_b), 64'(b));
                checkOutput("md_funct_latched", 64'(md_funct), 64'(f));
                checkOutput("busy_in_op", 64'(busy), 64'd1);
            end
            tick();
        end
        md_done = 1'b0;
        if (!stall_at_done) op_valid = 1'b0;
    endtask

    initial begin
        int stalls;
        int starts;

        rst = 1'b1; flush = 1'b0; stall_all = 1'b0; op_valid = 1'b0;
        op_funct = '0; op_a = '0; op_b = '0; md_done = 1'b0; md_result = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_stall", 64'(stall_req), 64'd0);
        checkOutput("rst_start", 64'(md_start), 64'd0);
        checkOutput("rst_abort", 64'(md_abort), 64'd0);
        checkOutput("rst_md_a", 64'(md_a), 64'd0);
        checkOutput("rst_timeout", 64'(timeout_err), 64'd0);

        // MULTU FFFFFFFF * 2, done on second cycle after start
        applyStimulus(6'h19, 32'hFFFF_FFFF, 32'd2, 2, 64'h0000_0001_FFFF_FFFE, 1'b0, stalls, starts);
        #1;
        checkOutput("multu_starts", 64'(starts), 64'd1);
        checkOutput("multu_stalls", 64'(stalls), 64'd2);
        checkOutput("multu_hi", 64'(hi), 64'h1);
        checkOutput("multu_lo", 64'(lo), 64'hFFFF_FFFE);
        checkOutput("multu_idle", 64'(busy), 64'd0);

        // DIV -7 / 2, done after 33 cycles
        applyStimulus(6'h1A, 32'hFFFF_FFF9, 32'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, stalls, starts);
        #1;
        checkOutput("div_starts", 64'(starts), 64'd1);
        checkOutput("div_stalls", 64'(stalls), 64'd33);
        checkOutput("div_hi", 64'(hi), 64'hFFFF_FFFF);
        checkOutput("div_lo", 64'(lo), 64'hFFFF_FFFD);

        // DIVU 100 / 7 with global stall at done and for 3 more cycles
        applyStimulus(6'h1B, 32'd100, 32'd7, 34, 64'h0000_0002_0000_000E, 1'b1, stalls, starts);
        for (int h = 0; h < 3; h++) begin
            md_done   = (h == 0);
            md_result = 64'hDEAD_BEEF_CAFE_F00D;
            #1;
            checkOutput("hold_busy", 64'(busy), 64'd0);
            checkOutput("hold_start", 64'(md_start), 64'd0);
            checkOutput("hold_stall", 64'(stall_req), 64'd0);
            if (md_start) starts++;
            tick();
        end
        md_done = 1'b0;
        stall_all = 1'b0;
        #1;
        checkOutput("hold_release_start", 64'(md_start), 64'd0);
        if (md_start) starts++;
        tick();
        op_valid = 1'b0;
        #1;
        checkOutput("divu_starts", 64'(starts), 64'd1);
        checkOutput("divu_hi", 64'(hi), 64'h2);
        checkOutput("divu_lo", 64'(lo), 64'hE);
        checkOutput("divu_idle", 64'(busy), 64'd0);

        // DIV with flush coincident with md_done
        op_valid = 1'b1; op_funct = 6'h1A; op_a = 32'd50; op_b = 32'd5;
        #1;
        checkOutput("flush_div_start", 64'(md_start), 64'd1);
        tick();
        tick();
        tick();
        md_done = 1'b1; flush = 1'b1; md_result = 64'h1111_2222_3333_4444;
        #1;
        checkOutput("flush_abort", 64'(md_abort), 64'd1);
        tick();
        md_done = 1'b0; flush = 1'b0; op_valid = 1'b0;
        #1;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_stall", 64'(stall_req), 64'd0);
        checkOutput("flush_abort_once", 64'(md_abort), 64'd0);
        checkOutput("flush_hi", 64'(hi), 64'h2);
        checkOutput("flush_lo", 64'(lo), 64'hE);

        // MTHI then MTLO back-to-back
        op_valid = 1'b1; op_funct = 6'h11; op_a = 32'h1234_5678;
        #1;
        checkOutput("mthi_stall", 64'(stall_req), 64'd0);
        tick();
        op_funct = 6'h13; op_a = 32'h9ABC_DEF0;
        #1;
        checkOutput("mtlo_stall", 64'(stall_req), 64'd0);
        tick();
        op_valid = 1'b0;
        #1;
        checkOutput("mt_hi", 64'(hi), 64'h1234_5678);
        checkOutput("mt_lo", 64'(lo), 64'h9ABC_DEF0);

        // Flush in IDLE blocks an MTHI write
        op_valid = 1'b1; op_funct = 6'h11; op_a = 32'h1111_1111; flush = 1'b1;
        tick();
        flush = 1'b0; op_valid = 1'b0;
        #1;
        checkOutput("flush_mthi_hi", 64'(hi), 64'h1234_5678);

        // Global stall blocks issue
        op_valid = 1'b1; op_funct = 6'h18; op_a = 32'd1; op_b = 32'd1; stall_all = 1'b1;
        #1;
        checkOutput("stalled_start", 64'(md_start), 64'd0);
        checkOutput("stalled_stall", 64'(stall_req), 64'd0);
        tick();
        op_valid = 1'b0; stall_all = 1'b0;
        #1;
        checkOutput("stalled_busy", 64'(busy), 64'd0);

        // Watchdog: unit never answers
        op_valid = 1'b1; op_funct = 6'h18; op_a = 32'd9; op_b = 32'd9;
        tick();
        for (int k = 1; k <= 64; k++) begin
            #1;
            checkOutput($sformatf("wd_abort_%0d", k), 64'(md_abort), 64'(k == 64));
            if (k == 64) op_valid = 1'b0;
            tick();
        end
        #1;
        checkOutput("wd_busy", 64'(busy), 64'd0);
        checkOutput("wd_flag", 64'(timeout_err), 64'd1);
        checkOutput("wd_hi", 64'(hi), 64'h1234_5678);
        checkOutput("wd_lo", 64'(lo), 64'h9ABC_DEF0);

        // Next MULT after the watchdog issues normally
        applyStimulus(6'h18, 32'd3, 32'd5, 3, 64'h0000_0000_0000_000F, 1'b0, stalls, starts);
        #1;
        checkOutput("post_wd_starts", 64'(starts), 64'd1);
        checkOutput("post_wd_stalls", 64'(stalls), 64'd3);
        checkOutput("post_wd_hi", 64'(hi), 64'h0);
        checkOutput("post_wd_lo", 64'(lo), 64'hF);
        checkOutput("post_wd_flag", 64'(timeout_err), 64'd1);

        // Reset clears the sticky flag
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst2_flag", 64'(timeout_err), 64'd0);
        checkOutput("rst2_lo", 64'(lo), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
